// File: rtl/dmem_pkg.sv
// Shared types and constants for the latency-configurable data memory.
package dmem_pkg;

    // Access state machine: accept in IDLE, count down in WAIT, complete in DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 256;

    // Width of an index able to address 'depth' entries (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DMEM_IDX_W = idx_width(DMEM_DEPTH);

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: byte-lane synchronous write, registered read port.
// The read register clears on reset and can be forced to zero so the
// controller can report a misaligned access with a zero data word.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int IDX_W  = idx_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    idx,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic                rd_clr,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Read register: holds its value until the next read or forced clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/data_memory_lat.sv
// MEM-stage data memory with configurable access latency, byte enables,
// pipeline stall generation and misalignment reporting. One access is
// outstanding at a time; the result commits on the edge entering DONE.
module data_memory_lat
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic                stall_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = idx_width(DEPTH);
    localparam int CNT_W = idx_width(LATENCY + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dmem_state_e      state;
    logic [CNT_W-1:0] cnt;

    // Live decode of the incoming request.
    logic             mis_live;
    logic [IDX_W-1:0] idx_live;
    logic             unused_addr_bits;

    assign mis_live         = |addr_i[1:0];
    assign idx_live         = addr_i[IDX_W+1:2];
    assign unused_addr_bits = ^addr_i[ADDR_W-1:IDX_W+2];

    // Request stage: copy of the accepted request, held while in WAIT.
    logic             we_p0;
    logic             mis_p0;
    logic [IDX_W-1:0] idx_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [NB-1:0]    be_p0;

    logic accept;
    logic commit;

    assign accept = (state == IDLE) && req_i;

    // Commit strobe: from WAIT on the last count, or directly from IDLE
    // when the access completes in a single cycle.
    always_comb begin
        commit = 1'b0;
        case (state)
            IDLE:    commit = req_i && (LATENCY == 1);
            WAIT:    commit = (cnt == CNT_ONE);
            default: commit = 1'b0;
        endcase
    end

    // A single-cycle access commits before the request stage is loaded,
    // so the commit operands come from the live inputs while in IDLE.
    logic              c_we;
    logic              c_mis;
    logic [IDX_W-1:0]  c_idx;
    logic [DATA_W-1:0] c_wdata;
    logic [NB-1:0]     c_be;

    assign c_we    = (state == IDLE) ? we_i     : we_p0;
    assign c_mis   = (state == IDLE) ? mis_live : mis_p0;
    assign c_idx   = (state == IDLE) ? idx_live : idx_p0;
    assign c_wdata = (state == IDLE) ? wdata_i  : wdata_p0;
    assign c_be    = (state == IDLE) ? be_i     : be_p0;

    // Capture the request on acceptance; data only, so no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_p0    <= we_i;
            mis_p0   <= mis_live;
            idx_p0   <= idx_live;
            wdata_p0 <= wdata_i;
            be_p0    <= be_i;
        end
    end

    // Access FSM with registered completion pulse and error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        cnt <= CNT_LOAD;
                        if (LATENCY == 1) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            err_o  <= mis_live;
                        end else begin
                            state <= WAIT;
                            err_o <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_ONE) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        err_o  <= mis_p0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    // The request still present here is the one just served.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall until the DONE cycle; held low while reset is asserted.
    assign stall_o = !rst_i && (((state == IDLE) && req_i) || (state == WAIT));

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk_i),
        .rst     (rst_i),
        .idx     (c_idx),
        .wr_en   (commit && c_we && !c_mis),
        .wr_be   (c_be),
        .wr_data (c_wdata),
        .rd_en   (commit && !c_we && !c_mis),
        .rd_clr  (commit && c_mis),
        .rd_data (rdata_o)
    );

endmodule

// File: doc/data_memory_lat.md
# data_memory_lat

Parametrised, multi-cycle data memory for the MEM stage of the pipeline, replacing the single-word, zero-latency data memory. It adds byte-enable writes, a configurable access latency, a stall output that freezes the pipeline while an access is in flight, and a misalignment error flag. Storage is synchronous, and every access runs through a small request/complete state machine.

## Interface
- `DATA_W`, 32: data word width; must be a multiple of 8.
- `DEPTH`, 256: number of words; power of two.
- `ADDR_W`, 32: byte-address width.
- `LATENCY`, 2: cycles from request acceptance to completion; must be ≥1.
- `clk_i` in 1: clock. One clock domain only.
- `rst_i` in 1: reset, asynchronous and active-high.
- `req_i` in 1: access request; held by the pipeline until completion.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in ADDR_W: byte address.
- `wdata_i` in DATA_W: write data, already lane-aligned.
- `be_i` in DATA_W/8: byte enables for writes. Ignored for reads.
- `stall_o` out 1: pipeline stall request; combinational.
- `done_o` out 1: one-cycle completion pulse.
- `rdata_o` out DATA_W: read data.
- `err_o` out 1: misaligned access; valid while `done_o` is high.

## Operation
- Word index is `addr_i[log2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- Misaligned access: `addr_i[1:0] != 0`.
  - No array write takes place.
  - `rdata_o` is set to 0 and `err_o` is 1 in the DONE cycle.
- FSM states are IDLE, WAIT and DONE.
- IDLE:
  - On `req_i`, latch `we_i`, `addr_i`, `wdata_i` and `be_i`, and load the counter with LATENCY-1.
  - Next state is DONE if LATENCY = 1, otherwise WAIT.
- WAIT:
  - If the counter equals 1, go to DONE; otherwise decrement.
  - Request inputs are ignored in WAIT.
- DONE: lasts exactly one cycle, then the FSM returns to IDLE. `req_i` sampled in DONE is treated as the old request and ignored.
- Commit happens on the edge entering DONE:
  - A write updates only the lanes whose `be` bit is set.
  - A read registers the word into `rdata_o`.
  - A write leaves `rdata_o` unchanged.
- `stall_o` = (IDLE & `req_i`) | WAIT. It is low in DONE, so the pipeline advances at the end of the DONE cycle.
- `done_o` = DONE. `err_o` is registered alongside `rdata_o` and is cleared on the next acceptance.
- Reset:
  - State goes to IDLE, the counter clears, and `rdata_o`, `err_o`, `done_o` and `stall_o` all become 0.
  - Array contents are not reset.
  - A pending request at reset is dropped and its write is never committed.

## Timing
- A request is accepted in cycle 0. `stall_o` is high for cycles 0 to LATENCY-1, and `done_o`, `rdata_o` and `err_o` are valid in cycle LATENCY.
- One access is outstanding at a time. The pipeline sees a stall of exactly LATENCY cycles per access.
- The earliest next acceptance is cycle LATENCY+1, with no back-to-back acceptance across DONE.
- Read-after-write to the same word in consecutive accesses returns the new data, since the write commits before the next acceptance.
- `rst_i` is asynchronous in all states and overrides every other input.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (IDLE/WAIT/DONE);
  - the default DATA_W;
  - a `clog2`-derived index-width constant.
- One sub-module, `dmem_array`: DEPTH×DATA_W storage with a byte-enable synchronous write and a registered read.
- The FSM, request latch, counter and stall logic live in `data_memory_lat`.

## Test plan
- **Basic write/read, LATENCY = 2.** Write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10. Required response: `stall_o` high 2 cycles per access, `done_o` in cycle 2, `rdata_o` = 0xDEADBEEF.
- **Byte-enable write.** Preload word 0x20 = 0x11223344, write 0xAABBCCDD with be=4'b0101, then read. Required response: 0x11BB33DD.
- **Misaligned access.** Write to address 0x13. Required response: `err_o` = 1 with `done_o`, and a subsequent read of 0x10 is unchanged.
- **Address wrap, DEPTH = 256.** Write to 0x400, then read 0x000. Required response: same data returned.
- **Reset mid-access.** Assert `rst_i` while in WAIT during a write to 0x30. Required response: all outputs 0 immediately, and a subsequent read of 0x30 returns the old contents.
- **LATENCY = 1 and LATENCY = 5 builds.** Issue back-to-back reads. Required response: `stall_o` exactly 1 and 5 cycles respectively, and `done_o` pulses spaced LATENCY+1 cycles apart.
